fir_mac_seq: RTL

FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

---
 rtl/fir_mac_seq_pkg.sv | 16 +
 rtl/fir_delay_line.sv | 37 +++
 rtl/fir_mac_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fir_mac_seq_pkg.sv
// Shared constants and FSM encoding for the symmetric FIR MAC sequencer.
package fir_mac_seq_pkg;

  localparam int NUM_TAP     = 33;
  localparam int DATA_WIDTH  = 3;
  localparam int COEFF_WIDTH = 16;
  localparam int OUT_WIDTH   = 23;
  localparam int ADDR_WIDTH  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/fir_delay_line.sv
// Symbol delay line x[0..NUM_TAP-1] with symmetric head/tail read at pair index k.
module fir_delay_line #(
  parameter int NUM_TAP    = 33,
  parameter int DATA_WIDTH = 3,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  iClk12M,
  input  logic                  iRst,
  input  logic                  iShift,
  input  logic [DATA_WIDTH-1:0] iSymbol,
  input  logic [ADDR_WIDTH-1:0] iIdx,
  output logic [DATA_WIDTH-1:0] oHead,
  output logic [DATA_WIDTH-1:0] oTail
);

  // The tail index reaches NUM_TAP-1, which can need one bit more than k itself.
  localparam int IW = $clog2(NUM_TAP);

  logic [DATA_WIDTH-1:0] rX [NUM_TAP];
  logic [IW-1:0]         headIdx;
  logic [IW-1:0]         tailIdx;

  assign headIdx = IW'(iIdx);
  assign tailIdx = IW'(NUM_TAP - 1) - headIdx;
  assign oHead   = rX[headIdx];
  assign oTail   = rX[tailIdx];

  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i < NUM_TAP; i++) rX[i] <= '0;
    end else if (iShift) begin
      rX[0] <= iSymbol;
      for (int i = 1; i < NUM_TAP; i++) rX[i] <= rX[i-1];
    end
  end

endmodule

// File: rtl/fir_mac_seq.sv
// Sequences an external pre-add/multiply/accumulate MAC over the symmetric
// tap pairs of the FIR, one pair per cycle, and captures the result.
//
// state   | meaning
// IDLE    | waiting for a sample strobe
// CALC    | driving tap k = 0..center to the MAC, one per cycle
// WAIT    | MAC holds the final sum; capture it into oFirOut
module fir_mac_seq
  import fir_mac_seq_pkg::*;
#(
  parameter int NUM_TAP    = fir_mac_seq_pkg::NUM_TAP,
  parameter int DATA_WIDTH = fir_mac_seq_pkg::DATA_WIDTH,
  parameter int OUT_WIDTH  = fir_mac_seq_pkg::OUT_WIDTH,
  parameter int ADDR_WIDTH = fir_mac_seq_pkg::ADDR_WIDTH
) (
  input  logic                  iClk12M,
  input  logic                  iRst,
  input  logic                  iEnSample,
  input  logic [DATA_WIDTH-1:0] iSymbol,
  output logic                  oEnAdd,
  output logic                  oEnAcc,
  output logic                  oEnMul,
  output logic                  oIsCenter,
  output logic [DATA_WIDTH-1:0] oDelayHead,
  output logic [DATA_WIDTH-1:0] oDelayTail,
  output logic [ADDR_WIDTH-1:0] oCoeffAddr,
  input  logic [OUT_WIDTH-1:0]  iMac,
  output logic [OUT_WIDTH-1:0]  oFirOut,
  output logic                  oFirValid,
  output logic                  oBusy,
  output logic                  oOverrun
);

  localparam int NUM_PAIR = (NUM_TAP - 1) / 2;
  localparam logic [ADDR_WIDTH-1:0] CENTER = ADDR_WIDTH'(NUM_PAIR);

  state_t                rState, nState;
  logic [ADDR_WIDTH-1:0] rTap, nTap;
  logic                  accept;
  logic [DATA_WIDTH-1:0] head, tail;
  logic [OUT_WIDTH-1:0]  rFirOut;
  logic                  rFirValid;
  logic                  rOverrun;

  fir_delay_line #(
    .NUM_TAP   (NUM_TAP),
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_delay (
    .iClk12M(iClk12M),
    .iRst   (iRst),
    .iShift (accept),
    .iSymbol(iSymbol),
    .iIdx   (rTap),
    .oHead  (head),
    .oTail  (tail)
  );

  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      rState <= ST_IDLE;
      rTap   <= '0;
    end else begin
      rState <= nState;
      rTap   <= nTap;
    end
  end

  always_comb begin
    nState     = rState;
    nTap       = rTap;
    accept     = 1'b0;
    oEnAdd     = 1'b0;
    oEnAcc     = 1'b0;
    oEnMul     = 1'b0;
    oIsCenter  = 1'b0;
    oDelayHead = '0;
    oDelayTail = '0;
    oCoeffAddr = '0;
    case (rState)
      ST_IDLE: begin
        if (iEnSample) begin
          accept = 1'b1;
          nTap   = '0;
          nState = ST_CALC;
        end
      end
      ST_CALC: begin
        oEnMul     = 1'b1;
        oCoeffAddr = rTap;
        oDelayHead = head;
        oDelayTail = tail;
        oIsCenter  = (rTap == CENTER);
        // First product loads the accumulator, the rest add onto it.
        oEnAdd     = (rTap == '0);
        oEnAcc     = (rTap != '0);
        if (rTap == CENTER) begin
          nTap   = '0;
          nState = ST_WAIT;
        end else begin
          nTap = rTap + 1'b1;
        end
      end
      ST_WAIT: nState = ST_IDLE;
      default: nState = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      rFirOut   <= '0;
      rFirValid <= 1'b0;
      rOverrun  <= 1'b0;
    end else begin
      rFirValid <= (rState == ST_WAIT);
      rOverrun  <= iEnSample && (rState != ST_IDLE);
      if (rState == ST_WAIT) rFirOut <= iMac;
    end
  end

  assign oFirOut   = rFirOut;
  assign oFirValid = rFirValid;
  assign oOverrun  = rOverrun;
  assign oBusy     = (rState != ST_IDLE);

endmodule
